// File: rtl/sa_tx_pkg.sv
// Shared widths and types for the SA transmit scheduler and its slot store.
// Constants only; no logic, no latency, no flow control.
package sa_tx_pkg;
  localparam int SA_TX_DW    = 57;
  localparam int SA_TX_SLOTS = 8;
  localparam int SA_TX_IDX_W = $clog2(SA_TX_SLOTS);

  typedef logic [SA_TX_DW-1:0]    sa_tx_entry_t;
  typedef logic [SA_TX_IDX_W-1:0] sa_tx_idx_t;
endpackage

// File: rtl/sa_tx_slot_file.sv
// Entry storage: SLOTS x DW flops, one synchronous write port and one combinational read port.
// Write lands on the rising edge; read has zero latency; no backpressure of its own.
module sa_tx_slot_file
  import sa_tx_pkg::*;
#(
  parameter int DW    = SA_TX_DW,
  parameter int SLOTS = SA_TX_SLOTS
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(SLOTS)-1:0] wr_idx,
  input  logic [DW-1:0]            wr_data,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] mem_q [SLOTS];

  // Payload is qualified by the scheduler's used bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_idx] <= wr_data;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/sa_tx_sched.sv
// Two-port round-robin scheduler into an 8-slot store, drained oldest-first; push-to-tx latency 1 cycle.
// a_ready/b_ready drop to 0 while full (full is registered, so a same-cycle pop does not admit a push).
module sa_tx_sched
  import sa_tx_pkg::*;
#(
  parameter int DW    = SA_TX_DW,
  parameter int SLOTS = SA_TX_SLOTS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  input  logic [DW-1:0]            a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [DW-1:0]            b_data,
  output logic                     b_ready,
  output logic                     tx_valid,
  output logic [DW-1:0]            tx_data,
  output logic [$clog2(SLOTS)-1:0] tx_slot,
  input  logic                     tx_ready,
  output logic [$clog2(SLOTS):0]   occupancy,
  output logic                     full,
  output logic                     empty
);

  localparam int IW = $clog2(SLOTS);
  localparam logic [IW:0] FULL_CNT = (IW+1)'(SLOTS);

  logic [SLOTS-1:0] used_q, used_d;
  logic [IW-1:0]    order_q [SLOTS];
  logic [IW-1:0]    order_d [SLOTS];
  logic [IW-1:0]    head_q, head_d;
  logic [IW-1:0]    tail_q, tail_d;
  logic [IW:0]      occ_q, occ_d;
  logic             rr_q, rr_d;

  logic             grant_a, grant_b, push, pop;
  logic [IW-1:0]    free_idx, head_slot;
  logic [DW-1:0]    wr_data, rd_data;

  assign full  = (occ_q == FULL_CNT);
  assign empty = (occ_q == '0);

  // rr_q=0 prefers A on contention, rr_q=1 prefers B.
  assign grant_a = !full && a_valid && (!b_valid || !rr_q);
  assign grant_b = !full && b_valid && (!a_valid ||  rr_q);
  assign push    = grant_a || grant_b;
  assign pop     = !empty && tx_ready;
  assign wr_data = grant_b ? b_data : a_data;

  // Uses the pre-pop mask, so a same-cycle push never reuses the slot being drained.
  always_comb begin
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!used_q[i]) free_idx = i[IW-1:0];
    end
  end

  assign head_slot = order_q[head_q];

  always_comb begin
    used_d  = used_q;
    order_d = order_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    rr_d    = rr_q;
    if (pop) begin
      used_d[head_slot] = 1'b0;
      head_d            = head_q + 1'b1;
    end
    if (push) begin
      used_d[free_idx] = 1'b1;
      order_d[tail_q]  = free_idx;
      tail_d           = tail_q + 1'b1;
      rr_d             = !rr_q;
    end
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      rr_q   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) order_q[i] <= '0;
    end else begin
      used_q  <= used_d;
      order_q <= order_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      rr_q    <= rr_d;
    end
  end

  sa_tx_slot_file #(
    .DW    (DW),
    .SLOTS (SLOTS)
  ) u_slot_file (
    .clk     (clk),
    .we      (push),
    .wr_idx  (free_idx),
    .wr_data (wr_data),
    .rd_idx  (head_slot),
    .rd_data (rd_data)
  );

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign tx_valid  = !empty;
  assign tx_slot   = empty ? '0 : head_slot;
  assign tx_data   = empty ? '0 : rd_data;
  assign occupancy = occ_q;

endmodule

// File: doc/sa_tx_sched.md
# sa_tx_sched

Transmit-side scheduler for the SA 8-slot entry store. Arbitrates between two requester ports, allocates free slots, and drains entries in strict arrival order through a valid/ready output. Replaces the implicit first-free-slot write and external clear mask with explicit, single-owner slot bookkeeping. Sits between the SA request sources and the link transmit stage.

## Interface
Parameters:
- DW, 57, entry width in bits
- SLOTS, 8, number of storage slots (power of two, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A has an entry
- a_data  in  DW  requester A entry
- a_ready  out  1  A entry accepted this cycle
- b_valid  in  1  requester B has an entry
- b_data  in  DW  requester B entry
- b_ready  out  1  B entry accepted this cycle
- tx_valid  out  1  oldest entry available
- tx_data  out  DW  oldest entry
- tx_slot  out  $clog2(SLOTS)  slot index holding tx_data
- tx_ready  in  1  consumer takes entry
- occupancy  out  $clog2(SLOTS)+1  slots in use
- full  out  1  occupancy == SLOTS
- empty  out  1  occupancy == 0

## Operation
- State: used mask [SLOTS], order FIFO of slot indices (SLOTS deep, head/tail pointers with wrap), occupancy counter, round-robin pointer rr (0=A preferred, 1=B preferred).
- Arbitration: at most one push per cycle. If !full:
  - only one valid → that port is granted;
  - both valid → the port selected by rr is granted.
- rr flips to the other port after every grant; it is unchanged when nothing is granted.
- a_ready/b_ready are high only for the granted port; both are 0 when full.
- Allocation: the granted entry is written to the lowest-index slot with used=0. That slot's used bit is set and its index is written at the order FIFO tail.
- Drain:
  - tx_valid = !empty;
  - tx_slot = order[head];
  - tx_data = slot[tx_slot].
- On tx_valid && tx_ready: clear the used bit for tx_slot and advance head.
- Counter: +1 on push only, −1 on pop only, unchanged on push+pop or idle. Never exceeds SLOTS or underflows.
- Simultaneous push+pop when full: pop is taken, push is refused that cycle (full is registered; no bypass). The freed slot becomes allocatable next cycle.
- Simultaneous push+pop with occupancy 1: the pop drains the old entry and the push lands in a different free slot. Allowed.
- Head/tail wrap modulo SLOTS.
- tx_data and tx_slot drive 0 while empty.
- Reset (including mid-operation): all entries are discarded. used=0, occupancy=0, head=tail=0, rr=0.
- Reset values: tx_valid=0, empty=1, full=0, occupancy=0, a_ready=b_ready=0, tx_data=0, tx_slot=0.
- Slot data registers are not reset.

## Timing
- Push-to-tx latency is 1 cycle: an entry accepted at edge N is visible on tx_valid/tx_data after edge N.
- Throughput: one push and one pop per cycle sustained when 0 < occupancy < SLOTS.
- a_ready/b_ready are combinational from a_valid/b_valid, rr and full. Requesters must not derive valid from ready.
- tx_valid, tx_slot and tx_data are combinational from registered state only; there is no path from tx_ready to them.
- A freed slot is reusable from the cycle after the pop.

## Structure
- Package sa_tx_pkg holds:
  - SA_TX_DW = 57, SA_TX_SLOTS = 8;
  - SA_TX_IDX_W = $clog2(SA_TX_SLOTS);
  - typedef sa_tx_entry_t (logic [SA_TX_DW-1:0]);
  - typedef sa_tx_idx_t.
- Sub-module sa_tx_slot_file holds the data:
  - SLOTS×DW registers, no reset;
  - inputs: we, wr_idx, wr_data, rd_idx;
  - output: rd_data (combinational mux).
- sa_tx_sched keeps all control: arbiter, lowest-free finder, order FIFO, counter.

## Test plan
- Reset then A pushes 0x0AA → a_ready=1 that cycle; next cycle tx_valid=1, tx_slot=0, tx_data=0x0AA, occupancy=1.
- A and B both valid for 4 cycles with tx_ready=0, values A=0x1.., B=0x2.. → grants A,B,A,B; slots 0–3 filled; draining yields A0,B0,A1,B1.
- 8 pushes with no pops → full=1, occupancy=8. A 9th valid gets ready=0. Pop + push in the same cycle → push refused; the push is accepted next cycle into the freed slot 0, and drain order stays by arrival.
- Fill slots 0–3, pop slots 0 and 1, push X → X goes to slot 0. Drain order: entries 2, 3, then X.
- Sustained push+pop for 20 cycles at occupancy 1 → occupancy stays 1, head/tail wrap correctly, data order preserved.
- Assert rst_n low with occupancy=5 → outputs go to reset values immediately (async). After release, empty=1 and the first push lands in slot 0.
